// File: rtl/lbm_pkg.sv
// Shared definitions for the D2Q9 BGK collision stage: direction indices,
// lattice velocity tables, Q0.10 equilibrium weights and small helpers.
package lbm_pkg;

  localparam int NDIR = 9;

  // Direction indices: rest, then counter-clockwise starting at east.
  localparam int DIR_REST = 0;
  localparam int DIR_E    = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_N    = 3;
  localparam int DIR_NW   = 4;
  localparam int DIR_W    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_S    = 7;
  localparam int DIR_SE   = 8;

  // Lattice velocity components per direction.
  localparam logic signed [1:0] C_X [NDIR] = '{2'sd0, 2'sd1, 2'sd1, 2'sd0, -2'sd1,
                                               -2'sd1, -2'sd1, 2'sd0, 2'sd1};
  localparam logic signed [1:0] C_Y [NDIR] = '{2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1,
                                               2'sd0, -2'sd1, -2'sd1, -2'sd1};

  // Equilibrium weights in Q0.10 (4/9, 1/9, 1/36).
  localparam int WEIGHT_FRAC = 10;
  localparam logic signed [11:0] W0    = 12'sd455;
  localparam logic signed [11:0] WAXIS = 12'sd114;
  localparam logic signed [11:0] WDIAG = 12'sd28;

  // Pipeline depth of the per-cell datapath.
  localparam int PIPE_LATENCY = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_WRITE   = 3'd4
  } state_t;

  // Opposite direction: rest maps to itself, others rotate by half a turn.
  function automatic int unsigned opposite(input int unsigned i);
    if (i == 0) begin
      return 0;
    end else begin
      return ((i + 3) % 8) + 1;
    end
  endfunction

  // Weight for direction i: rest, axis (odd) or diagonal (even).
  function automatic logic signed [11:0] weight(input int i);
    if (i == DIR_REST) begin
      return W0;
    end else if ((i % 2) == 1) begin
      return WAXIS;
    end else begin
      return WDIAG;
    end
  endfunction

  // Saturate a signed value into the unsigned 8-bit distribution range.
  function automatic logic [7:0] clamp_u8(input logic signed [26:0] x);
    if (x < 27'sd0) begin
      return 8'd0;
    end else if (x > 27'sd255) begin
      return 8'd255;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/collide_cell.sv
// Three-stage BGK collision datapath for one D2Q9 cell:
// moments -> weighted equilibrium products -> shift/clamp/relax.
module collide_cell
  import lbm_pkg::*;
#(
  parameter int TAU_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [8:0][7:0] f_in,
  output logic            valid_out,
  output logic [8:0][7:0] f_out
);

  function automatic logic signed [10:0] ext11(input logic [7:0] f);
    return $signed({3'b000, f});
  endfunction

  logic [11:0]         rho_s;
  logic signed [10:0]  jx_s;
  logic signed [10:0]  jy_s;
  logic [11:0]         rho_r;
  logic signed [10:0]  jx_r;
  logic signed [10:0]  jy_r;
  logic [8:0][7:0]     f1_r;
  logic                v1_r;

  logic signed [11:0]  cj_s   [NDIR];
  logic signed [14:0]  s_s    [NDIR];
  logic signed [26:0]  prod_s [NDIR];
  logic signed [26:0]  prod_r [NDIR];
  logic [8:0][7:0]     f2_r;
  logic                v2_r;

  logic [7:0]          feq_s  [NDIR];
  logic signed [9:0]   diff_s [NDIR];
  logic signed [9:0]   nf_s   [NDIR];
  logic [8:0][7:0]     fnew_s;

  // Stage 1 combinational: density and momentum.
  always_comb begin
    rho_s = 12'd0;
    for (int i = 0; i < NDIR; i++) begin
      rho_s = rho_s + {4'd0, f_in[i]};
    end
    jx_s = ext11(f_in[DIR_E]) + ext11(f_in[DIR_NE]) + ext11(f_in[DIR_SE])
         - ext11(f_in[DIR_NW]) - ext11(f_in[DIR_W]) - ext11(f_in[DIR_SW]);
    jy_s = ext11(f_in[DIR_NE]) + ext11(f_in[DIR_N]) + ext11(f_in[DIR_NW])
         - ext11(f_in[DIR_SW]) - ext11(f_in[DIR_S]) - ext11(f_in[DIR_SE]);
  end

  // Stage 1 register: moments plus the raw distributions for later relaxing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rho_r <= 12'd0;
      jx_r  <= 11'sd0;
      jy_r  <= 11'sd0;
      f1_r  <= '0;
      v1_r  <= 1'b0;
    end else begin
      rho_r <= rho_s;
      jx_r  <= jx_s;
      jy_r  <= jy_s;
      f1_r  <= f_in;
      v1_r  <= valid_in;
    end
  end

  // Stage 2 combinational: c_i.j, s_i = rho + 3*c_i.j, and W_i*s_i.
  always_comb begin
    for (int i = 0; i < NDIR; i++) begin
      cj_s[i] = 12'sd0;
      if (C_X[i] == 2'sd1) begin
        cj_s[i] = cj_s[i] + 12'(jx_r);
      end else if (C_X[i] == -2'sd1) begin
        cj_s[i] = cj_s[i] - 12'(jx_r);
      end else begin
        cj_s[i] = cj_s[i];
      end
      if (C_Y[i] == 2'sd1) begin
        cj_s[i] = cj_s[i] + 12'(jy_r);
      end else if (C_Y[i] == -2'sd1) begin
        cj_s[i] = cj_s[i] - 12'(jy_r);
      end else begin
        cj_s[i] = cj_s[i];
      end
      s_s[i]    = $signed({3'b000, rho_r}) + 15'(cj_s[i]) + (15'(cj_s[i]) <<< 1);
      prod_s[i] = 27'(weight(i)) * 27'(s_s[i]);
    end
  end

  // Stage 2 register: equilibrium products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIR; i++) begin
        prod_r[i] <= 27'sd0;
      end
      f2_r <= '0;
      v2_r <= 1'b0;
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        prod_r[i] <= prod_s[i];
      end
      f2_r <= f1_r;
      v2_r <= v1_r;
    end
  end

  // Stage 3 combinational: floor shift, clamp feq, relax toward it, clamp.
  always_comb begin
    fnew_s = '0;
    for (int i = 0; i < NDIR; i++) begin
      feq_s[i]  = clamp_u8(prod_r[i] >>> WEIGHT_FRAC);
      diff_s[i] = $signed({2'b00, feq_s[i]}) - $signed({2'b00, f2_r[i]});
      nf_s[i]   = $signed({2'b00, f2_r[i]}) + (diff_s[i] >>> TAU_SHIFT);
      fnew_s[i] = clamp_u8(27'(nf_s[i]));
    end
  end

  // Stage 3 register: post-collision distributions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      f_out     <= fnew_s;
      valid_out <= v2_r;
    end
  end

endmodule

// File: rtl/collision.sv
// D2Q9 BGK collision pass: walks every cell address, reads the nine banks,
// relaxes the cell through collide_cell and writes the result in place.
module collision
  import lbm_pkg::*;
#(
  parameter int HPIXELS    = 64,
  parameter int VPIXELS    = 48,
  parameter int RW_LATENCY = 3,
  parameter int TAU_SHIFT  = 1,
  parameter int BRAM_SIZE  = $clog2(HPIXELS * VPIXELS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [8:0][7:0]           data_in,
  output logic [8:0][7:0]           data_out,
  output logic [8:0][BRAM_SIZE-1:0] addr_out,
  output logic                      valid_data_out,
  output logic                      done
);

  localparam logic [BRAM_SIZE-1:0] LAST_CELL = BRAM_SIZE'(HPIXELS * VPIXELS - 1);
  localparam logic [BRAM_SIZE-1:0] ONE_CELL  = BRAM_SIZE'(1);
  localparam logic [7:0]           WAIT_LAST = 8'(RW_LATENCY - 1);
  localparam logic [7:0]           PIPE_LAST = 8'(PIPE_LATENCY - 1);

  state_t                state_r;
  state_t                state_nxt;
  logic [7:0]            cnt_r;
  logic [BRAM_SIZE-1:0]  cell_r;
  logic [BRAM_SIZE-1:0]  addr_r;
  logic                  capture_s;
  logic                  cell_valid;
  logic [8:0][7:0]       cell_fout;

  // Bank data is sampled on the last wait cycle.
  assign capture_s = (state_r == ST_WAIT) && (cnt_r == WAIT_LAST);

  // All nine bank lanes carry the same cell address.
  assign addr_out = {9{addr_r}};

  collide_cell #(
    .TAU_SHIFT (TAU_SHIFT)
  ) u_collide_cell (
    .clk       (clk_in),
    .rst       (rst_in),
    .valid_in  (capture_s),
    .f_in      (data_in),
    .valid_out (cell_valid),
    .f_out     (cell_fout)
  );

  // Next-state logic of the cell sequencer.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_nxt = ST_COMPUTE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_COMPUTE: begin
        if (cnt_r == PIPE_LAST) begin
          state_nxt = ST_WRITE;
        end else begin
          state_nxt = ST_COMPUTE;
        end
      end
      ST_WRITE: begin
        if (cell_r == LAST_CELL) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_READ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and per-state cycle counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt;
      if (state_nxt != state_r) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Cell counter: cleared on start and after the last cell, advanced per write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cell_r <= '0;
    end else if ((state_r == ST_IDLE) && start_in) begin
      cell_r <= '0;
    end else if (state_r == ST_WRITE) begin
      if (cell_r == LAST_CELL) begin
        cell_r <= '0;
      end else begin
        cell_r <= cell_r + ONE_CELL;
      end
    end else begin
      cell_r <= cell_r;
    end
  end

  // Registered bank-side outputs: address, write data, write strobe, done.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_r         <= '0;
      data_out       <= '0;
      valid_data_out <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (state_r == ST_READ) begin
        addr_r <= cell_r;
      end else begin
        addr_r <= addr_r;
      end
      if ((state_nxt == ST_WRITE) && cell_valid) begin
        data_out <= cell_fout;
      end else begin
        data_out <= data_out;
      end
      valid_data_out <= (state_nxt == ST_WRITE) && cell_valid;
      done           <= (state_r == ST_WRITE) && (cell_r == LAST_CELL);
    end
  end

endmodule

// File: tb/tb_collision.sv
// Directed bench for collision on a 4x2 lattice: reset state, equilibrium
// arithmetic on hand-computed vectors, write sequencing and mid-pass reset.
module tb_collision;

  localparam int AW = 3;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                start_in;
  logic [8:0][7:0]     data_in;
  logic [8:0][7:0]     data_out;
  logic [8:0][AW-1:0]  addr_out;
  logic                valid_data_out;
  logic                done;

  int checks   = 0;
  int failures = 0;

  collision #(
    .HPIXELS    (4),
    .VPIXELS    (2),
    .RW_LATENCY (3),
    .TAU_SHIFT  (1)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .data_in        (data_in),
    .data_out       (data_out),
    .addr_out       (addr_out),
    .valid_data_out (valid_data_out),
    .done           (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0][7:0] mk(input logic [7:0] f0, input logic [7:0] f1,
                                         input logic [7:0] f2, input logic [7:0] f3,
                                         input logic [7:0] f4, input logic [7:0] f5,
                                         input logic [7:0] f6, input logic [7:0] f7,
                                         input logic [7:0] f8);
    return {f8, f7, f6, f5, f4, f3, f2, f1, f0};
  endfunction

  // One full pass with constant bank data. Cell n is written on negedge 8+8n
  // after start, done follows the last write by one cycle.
  task automatic run_pass(input string tag, input logic [8:0][7:0] din,
                          input logic [8:0][7:0] exp, input bit mid_start);
    int nw;
    int ni;
    bit seen_done;
    data_in = din;
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    ni = 1;
    nw = 0;
    seen_done = 1'b0;
    while (!seen_done && ni < 120) begin
      start_in = (mid_start && ni == 20);
      @(negedge clk_in);
      ni++;
      if (valid_data_out) begin
        chk({tag, "_data"}, data_out, exp);
        chk({tag, "_addr"}, addr_out, {9{AW'(nw)}});
        chk({tag, "_wcyc"}, ni, 8 + 8 * nw);
        nw++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "_nwrites"}, nw, 8);
        chk({tag, "_donecyc"}, ni, 65);
      end
    end
    start_in = 1'b0;
    chk({tag, "_done_seen"}, seen_done, 1'b1);
    @(negedge clk_in);
    chk({tag, "_done_1cyc"}, done, 1'b0);
    chk({tag, "_idle_nowr"}, valid_data_out, 1'b0);
  endtask

  initial begin
    int waited;
    int stray_wr;
    int stray_done;
    logic [8:0][7:0] rest_in;
    logic [8:0][7:0] rest_exp;

    rst_in   = 1'b1;
    start_in = 1'b0;
    data_in  = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_addr",  addr_out, '0);
    chk("rst_data",  data_out, '0);
    chk("rst_valid", valid_data_out, 1'b0);
    chk("rst_done",  done, 1'b0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("idle_valid", valid_data_out, 1'b0);

    // rho=92, j=0: feq0=40, feq_axis=10, feq_diag=2; 3+((2-3)>>>1)=2.
    rest_in  = mk(8'd40, 8'd10, 8'd3, 8'd10, 8'd3, 8'd10, 8'd3, 8'd10, 8'd3);
    rest_exp = mk(8'd40, 8'd10, 8'd2, 8'd10, 8'd2, 8'd10, 8'd2, 8'd10, 8'd2);
    run_pass("rest", rest_in, rest_exp, 1'b1);

    // East beam: rho=100, jx=100. feq: f0=44, E=44, NE/SE=10, N/S=11,
    // W=-23->0, NW/SW=-6->0. Relaxed by half toward feq.
    run_pass("beam_e", mk(8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
             mk(8'd22, 8'd72, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd5, 8'd5), 1'b0);

    // North beam: rho=100, jy=100. NE/NW=5, E/W=5, S/SW/SE=0.
    run_pass("beam_n", mk(8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
             mk(8'd22, 8'd5, 8'd5, 8'd72, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0), 1'b0);

    // Saturation: rho=2295, feq0 and feq_axis clamp to 255, feq_diag=62.
    run_pass("sat", {9{8'd255}},
             mk(8'd255, 8'd255, 8'd158, 8'd255, 8'd158, 8'd255, 8'd158, 8'd255, 8'd158), 1'b0);

    // All zeros still produce a write per cell.
    run_pass("zero", '0, '0, 1'b0);

    // Reset during cell 3's compute phase.
    data_in = rest_in;
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    waited = 0;
    while (!(valid_data_out && addr_out[0] == AW'(2)) && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    chk("mid_reach_cell2", waited < 100, 1'b1);
    repeat (6) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_addr",  addr_out, '0);
    chk("mid_rst_data",  data_out, '0);
    chk("mid_rst_valid", valid_data_out, 1'b0);
    chk("mid_rst_done",  done, 1'b0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    stray_wr = 0;
    stray_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (valid_data_out) stray_wr++;
      if (done) stray_done++;
    end
    chk("mid_no_write", stray_wr, 0);
    chk("mid_no_done",  stray_done, 0);

    run_pass("restart", rest_in, rest_exp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
